// File: rtl/fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_read_ctrl
//  Description : Read-side controller of an asynchronous FIFO (clk_r domain).
//                Synchronises the write Gray pointer, derives empty and
//                occupancy, drives the BRAM read address, absorbs the BRAM's
//                one-cycle read latency and presents words on a valid/ready
//                stream through a 2-entry output buffer at full throughput.
//  Ports       : clk_r, rst_r        - read clock, synchronous active-high reset
//                wr_ptr_gray_w       - write pointer (Gray) from clk_w domain
//                rd_ptr_gray         - registered read pointer (Gray) to clk_w
//                rd_addr / rd_data   - BRAM read address / registered read data
//                m_data/m_valid/m_ready - output stream
//                empty, rd_count     - unfetched words still held in BRAM
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_read_ctrl #(
    parameter int ADDR_WIDTH  = 11,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_r,
    input  logic                  rst_r,
    input  logic [ADDR_WIDTH:0]   wr_ptr_gray_w,
    output logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   rd_count
);

    localparam int PW = ADDR_WIDTH + 1;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // ------------------------------------------------------------------
    // Write-pointer synchroniser
    // ------------------------------------------------------------------
    logic [PW-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk_r) begin
        if (rst_r) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= wr_ptr_gray_w;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    logic [PW-1:0] w_wq;
    logic [PW-1:0] w_wbin;

    assign w_wq   = sync_q[SYNC_STAGES-1];
    assign w_wbin = gray2bin(w_wq);

    // ------------------------------------------------------------------
    // Read pointer, fetch decision
    // ------------------------------------------------------------------
    logic [PW-1:0]         rd_ptr_bin_q, rd_ptr_bin_d;
    logic [PW-1:0]         rd_ptr_gray_q, rd_ptr_gray_d;
    logic                  pending_q, pending_d;
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

    logic          w_empty;
    logic          w_pop;
    logic [2:0]    w_occ;
    logic          w_fetch;
    logic [PW-1:0] w_ptr_inc;

    assign w_empty   = (rd_ptr_gray_q == w_wq);
    assign w_pop     = (buf_cnt_q != 2'd0) && m_ready;
    // Words committed to the output path once this cycle's pop is accounted
    // for; the pop can only happen when buf_cnt_q >= 1, so no underflow.
    assign w_occ     = {2'b00, pending_q} + {1'b0, buf_cnt_q} - {2'b00, w_pop};
    assign w_fetch   = !w_empty && (w_occ < 3'd2);
    assign w_ptr_inc = rd_ptr_bin_q + PW'(1);

    always_comb begin
        rd_ptr_bin_d  = rd_ptr_bin_q;
        rd_ptr_gray_d = rd_ptr_gray_q;
        pending_d     = w_fetch;
        if (w_fetch) begin
            rd_ptr_bin_d  = w_ptr_inc;
            rd_ptr_gray_d = bin2gray(w_ptr_inc);
        end
    end

    // ------------------------------------------------------------------
    // 2-entry output buffer; buf0 is the head and drives the stream.
    // A word written while pending lands behind any word still buffered,
    // so ordering is preserved when pop and write coincide.
    // ------------------------------------------------------------------
    always_comb begin
        buf0_d    = buf0_q;
        buf1_d    = buf1_q;
        buf_cnt_d = buf_cnt_q;
        case ({w_pop, pending_q})
            2'b10: begin
                buf0_d    = buf1_q;
                buf_cnt_d = buf_cnt_q - 2'd1;
            end
            2'b01: begin
                if (buf_cnt_q == 2'd0) begin
                    buf0_d = rd_data;
                end else begin
                    buf1_d = rd_data;
                end
                buf_cnt_d = buf_cnt_q + 2'd1;
            end
            2'b11: begin
                if (buf_cnt_q == 2'd1) begin
                    buf0_d = rd_data;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = rd_data;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_r) begin
        if (rst_r) begin
            rd_ptr_bin_q  <= '0;
            rd_ptr_gray_q <= '0;
            pending_q     <= 1'b0;
            buf_cnt_q     <= 2'd0;
            buf0_q        <= '0;
            buf1_q        <= '0;
        end else begin
            rd_ptr_bin_q  <= rd_ptr_bin_d;
            rd_ptr_gray_q <= rd_ptr_gray_d;
            pending_q     <= pending_d;
            buf_cnt_q     <= buf_cnt_d;
            buf0_q        <= buf0_d;
            buf1_q        <= buf1_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all from registers except empty/rd_count, which come from
    // registered pointers only (no path from m_ready).
    // ------------------------------------------------------------------
    assign rd_ptr_gray = rd_ptr_gray_q;
    assign rd_addr     = rd_ptr_bin_q[ADDR_WIDTH-1:0];
    assign m_data      = buf0_q;
    assign m_valid     = (buf_cnt_q != 2'd0);
    assign empty       = w_empty;
    assign rd_count    = w_wbin - rd_ptr_bin_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_read_ctrl
//  Description : Self-checking bench for fifo_read_ctrl with a registered
//                BRAM model and a write-side pointer model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_read_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int SS    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic [AW:0]   wr_gray;
    logic [AW:0]   rd_gray;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          empty;
    logic [AW:0]   rd_count;

    fifo_read_ctrl #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk_r         (clk),
        .rst_r         (rst),
        .wr_ptr_gray_w (wr_gray),
        .rd_ptr_gray   (rd_gray),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .empty         (empty),
        .rd_count      (rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: registered read
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) rd_data <= mem[rd_addr];

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] q [$];
    logic [AW:0]   wp;
    int            popped;
    logic [AW:0]   prev_gray;
    bit            gray_ok = 1'b0;
    bit            mon_en  = 1'b0;
    bit            s_valid;
    bit            saw_wrap;

    function automatic logic [AW:0] b2g(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        mem[wp[AW-1:0]] = d;
        wp      = wp + 1'b1;
        wr_gray = b2g(wp);
        q.push_back(d);
    endtask

    // One clock cycle: sample at the falling edge, return 1 time unit after
    // the next rising edge so the caller can drive inputs.
    task automatic cycle();
        logic [DW-1:0] exp_d;
        @(negedge clk);
        s_valid = m_valid;
        if (mon_en && !rst) begin
            if (m_valid && m_ready) begin
                checks++;
                assert (q.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_underrun: observed=pop data=%0h expected=no_transfer", m_data);
                end
                if (q.size() != 0) begin
                    exp_d = q.pop_front();
                    chk("sb_data", 32'(m_data), 32'(exp_d));
                    popped++;
                end
            end
            if (gray_ok) begin
                chk("gray_step", 32'($countones(rd_gray ^ prev_gray) <= 1), 32'd1);
                if (prev_gray == 5'b10000 && rd_gray == 5'b00000) saw_wrap = 1'b1;
            end
            chk("count_le_depth", 32'(rd_count <= DEPTH), 32'd1);
        end
        prev_gray = rd_gray;
        gray_ok   = mon_en && !rst;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        wp      = '0;
        wr_gray = '0;
        q.delete();
        cycle();
        rst     = 1'b0;
        mon_en  = 1'b1;
    endtask

    initial begin
        int n;
        int run;
        int written;

        rst     = 1'b1;
        m_ready = 1'b0;
        wr_gray = '0;
        wp      = '0;
        popped  = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        @(posedge clk);
        #1;

        // 1: reset state
        do_reset();
        chk("t1_m_valid", 32'(m_valid), 32'd0);
        chk("t1_empty", 32'(empty), 32'd1);
        chk("t1_rd_gray", 32'(rd_gray), 32'd0);
        chk("t1_rd_count", 32'(rd_count), 32'd0);
        chk("t1_rd_addr", 32'(rd_addr), 32'd0);
        chk("t1_m_data", 32'(m_data), 32'd0);

        // 2: single word
        m_ready = 1'b1;
        write_word(8'hA5);
        cycle();
        chk("t2_empty_1cyc", 32'(empty), 32'd1);
        cycle();
        chk("t2_empty_2cyc", 32'(empty), 32'd0);
        chk("t2_rd_count", 32'(rd_count), 32'd1);
        chk("t2_rd_addr", 32'(rd_addr), 32'd0);
        cycle();
        chk("t2_rd_gray", 32'(rd_gray), 32'd1);
        chk("t2_empty_after", 32'(empty), 32'd1);
        chk("t2_valid_lat1", 32'(m_valid), 32'd0);
        cycle();
        chk("t2_valid", 32'(m_valid), 32'd1);
        chk("t2_data", 32'(m_data), 32'hA5);
        cycle();
        chk("t2_valid_pulse", 32'(m_valid), 32'd0);
        chk("t2_sb_empty", 32'(q.size()), 32'd0);

        // 3: backpressure
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            write_word(8'(8'h10 + i));
            cycle();
        end
        for (int i = 0; i < 8; i++) cycle();
        chk("t3_rd_addr", 32'(rd_addr), 32'd2);
        chk("t3_rd_count", 32'(rd_count), 32'd2);
        chk("t3_valid", 32'(m_valid), 32'd1);
        chk("t3_hold_data0", 32'(m_data), 32'h10);
        for (int i = 0; i < 3; i++) cycle();
        chk("t3_hold_data1", 32'(m_data), 32'h10);
        chk("t3_hold_valid", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            cycle();
            n++;
        end
        chk("t3_drain", 32'(q.size()), 32'd0);

        // 4: throughput from a full FIFO
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = 8'(8'h40 + i);
            q.push_back(8'(8'h40 + i));
        end
        wp      = 5'(DEPTH);
        wr_gray = b2g(wp);
        n = 0;
        s_valid = 1'b0;
        while (!s_valid && n < 20) begin
            cycle();
            n++;
        end
        chk("t4_start", 32'(s_valid), 32'd1);
        run = 0;
        while (s_valid && run < 40) begin
            run++;
            cycle();
        end
        chk("t4_run_len", 32'(run), 32'(DEPTH));
        chk("t4_sb_empty", 32'(q.size()), 32'd0);

        // 5: pointer wrap with random backpressure
        do_reset();
        popped   = 0;
        written  = 0;
        saw_wrap = 1'b0;
        for (int c = 0; c < 800 && popped < 40; c++) begin
            if (written < 40 && (written - popped) < DEPTH) begin
                write_word(8'(8'h80 + written));
                written++;
            end
            m_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        chk("t5_popped", 32'(popped), 32'd40);
        chk("t5_saw_wrap", 32'(saw_wrap), 32'd1);

        // 6: reset mid-stream with a fetch in flight
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mem[i] = 8'(8'hE0 + i);
            q.push_back(8'(8'hE0 + i));
        end
        wp      = 5'd8;
        wr_gray = b2g(wp);
        n = 0;
        s_valid = 1'b0;
        while (!s_valid && n < 20) begin
            cycle();
            n++;
        end
        chk("t6_streaming", 32'(s_valid), 32'd1);
        cycle();
        do_reset();
        chk("t6_valid_after_rst", 32'(m_valid), 32'd0);
        chk("t6_gray_after_rst", 32'(rd_gray), 32'd0);
        chk("t6_empty_after_rst", 32'(empty), 32'd1);
        for (int i = 0; i < 6; i++) cycle();
        chk("t6_no_stale", 32'(m_valid), 32'd0);
        write_word(8'h3C);
        n = 0;
        while (q.size() != 0 && n < 12) begin
            cycle();
            n++;
        end
        chk("t6_new_word", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
